display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter_pkg.sv | 15 +
 rtl/display_rr_pick.sv | 27 ++
 rtl/display_arbiter.sv | 133 +++++++++++++
 tb/tb_display_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared defaults and FSM encoding for the display arbiter.
package display_arbiter_pkg;

  localparam int NUM_W_DEF     = 32;
  localparam int N_REQ_DEF     = 4;
  localparam int DWELL_CYC_DEF = 50_000_000;
  localparam int IDX_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/display_rr_pick.sv
// Round-robin search: first requester strictly after last_i, wrapping,
// with last_i itself as the final candidate.
module display_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] next_o
);

  // Walk from the farthest candidate down so the nearest one wins.
  always_comb begin
    found_o = 1'b0;
    next_o  = last_i;
    for (int k = N_REQ; k >= 1; k--) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_i) + k) % N_REQ);
      if (req_i[idx]) begin
        found_o = 1'b1;
        next_o  = idx;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Rotates display ownership among requesters with a minimum dwell time,
// plus a manual override that pins one source.
//   state    | meaning
//   ST_IDLE  | no owner, waiting for any request
//   ST_SHOW  | owner granted, dwell counter running
//   ST_FORCE | override, force_sel shown regardless of req
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int NUM_W     = NUM_W_DEF,
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DWELL_CYC = DWELL_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*NUM_W-1:0] data,
  input  logic                   lock,
  input  logic                   force_en,
  input  logic [IDX_W-1:0]       force_sel,
  output logic [N_REQ-1:0]       grant,
  output logic [NUM_W-1:0]       num,
  output logic [IDX_W-1:0]       src,
  output logic                   valid
);

  localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_W-1:0]   data_arr [N_REQ];
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               do_arb;
  logic               dwell_done;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = data[g*NUM_W +: NUM_W];
  end

  display_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .last_i  (src_q),
    .found_o (pick_found),
    .next_o  (pick_idx)
  );

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign dwell_done = (cnt_q == CNT_W'(DWELL_CYC - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    num_d   = num_q;
    src_d   = src_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    do_arb  = 1'b0;

    if (force_en) begin
      state_d = ST_FORCE;
      src_d   = force_sel;
      grant_d = onehot(force_sel);
      num_d   = data_arr[force_sel];
      valid_d = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SHOW: begin
          // Owner drop beats both lock and dwell expiry.
          if (!req[src_q] || (!lock && dwell_done)) begin
            do_arb = 1'b1;
          end else begin
            num_d = data_arr[src_q];
            if (!lock) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: do_arb = 1'b1;
      endcase

      if (do_arb) begin
        cnt_d = '0;
        if (pick_found) begin
          state_d = ST_SHOW;
          src_d   = pick_idx;
          grant_d = onehot(pick_idx);
          num_d   = data_arr[pick_idx];
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      num_q   <= '0;
      src_q   <= IDX_W'(N_REQ - 1);
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      num_q   <= num_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign num   = num_q;
  assign src   = src_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed vector table, hand
// sequences for lock and async reset, then random stimulus vs a model.
module tb_display_arbiter;

  localparam int DWELL = 4;
  localparam logic [31:0] D0 = 32'h1234_5678;
  localparam logic [31:0] D1 = 32'hBBBB_0001;
  localparam logic [31:0] D2 = 32'hCCCC_0002;
  localparam logic [31:0] D3 = 32'hDDDD_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] dv [4];
  logic [127:0] data;
  logic        lock;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [3:0]  grant;
  logic [31:0] num;
  logic [1:0]  src;
  logic        valid;

  int n_cmp = 0;
  int n_bad = 0;

  assign data = {dv[3], dv[2], dv[1], dv[0]};

  always #5 clk = ~clk;

  display_arbiter #(
    .NUM_W     (32),
    .N_REQ     (4),
    .DWELL_CYC (DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .lock      (lock),
    .force_en  (force_en),
    .force_sel (force_sel),
    .grant     (grant),
    .num       (num),
    .src       (src),
    .valid     (valid)
  );

  typedef struct {
    logic [3:0]  req;
    logic        lock;
    logic        fen;
    logic [1:0]  fsel;
    logic [3:0]  grant;
    logic [1:0]  src;
    logic        valid;
    logic [31:0] num;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic [3:0] r, logic l, logic fe, logic [1:0] fs,
                              logic [3:0] g, logic [1:0] s, logic v, logic [31:0] n);
    vec_t t;
    t.req = r; t.lock = l; t.fen = fe; t.fsel = fs;
    t.grant = g; t.src = s; t.valid = v; t.num = n;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic [31:0] en);
    n_cmp++;
    if (grant !== eg || src !== es || valid !== ev || num !== en) begin
      n_bad++;
      $display("FAIL %s: got grant=%b src=%0d valid=%b num=%h, want grant=%b src=%0d valid=%b num=%h",
               nm, grant, src, valid, num, eg, es, ev, en);
    end
  endtask

  // Reference model: owner (-1 = none), last shown index, cycles of unlocked tenure.
  int          m_owner;
  int          m_last;
  int          m_ten;
  bit          m_forced;
  logic [31:0] m_num;

  function automatic int m_pick(logic [3:0] r, int last);
    int best = -1;
    int bd = 99;
    for (int i = 0; i < 4; i++) begin
      int d = (i - last - 1 + 8) % 4;
      if (r[i] && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_last = 3; m_ten = 0; m_forced = 0; m_num = '0;
  endtask

  task automatic m_arb();
    int p = m_pick(req, m_last);
    m_ten = 0;
    m_forced = 0;
    if (p < 0) m_owner = -1;
    else begin
      m_owner = p;
      m_last = p;
      m_num = dv[p];
    end
  endtask

  task automatic m_step();
    if (force_en) begin
      m_owner = int'(force_sel); m_last = m_owner; m_ten = 0;
      m_num = dv[force_sel]; m_forced = 1;
    end else if (m_forced || m_owner < 0 || !req[m_owner]) begin
      m_arb();
    end else begin
      if (!lock) m_ten++;
      if (m_ten == DWELL) m_arb();
      else m_num = dv[m_owner];
    end
  endtask

  initial begin
    logic [3:0] eg;
    rst = 1'b1; req = '0; lock = 1'b0; force_en = 1'b0; force_sel = '0;
    dv[0] = D0; dv[1] = D1; dv[2] = D2; dv[3] = D3;

    tbl[0]  = mk(4'b0001, 0, 0, 0, 4'b0001, 0, 1, D0);
    for (int i = 1; i <= 3; i++)  tbl[i] = mk(4'b0101, 0, 0, 0, 4'b0001, 0, 1, D0);
    for (int i = 4; i <= 7; i++)  tbl[i] = mk(4'b0101, 0, 0, 0, 4'b0100, 2, 1, D2);
    for (int i = 8; i <= 11; i++) tbl[i] = mk(4'b0101, 0, 0, 0, 4'b0001, 0, 1, D0);
    tbl[12] = mk(4'b0101, 0, 0, 0, 4'b0100, 2, 1, D2);
    tbl[13] = mk(4'b0101, 0, 0, 0, 4'b0100, 2, 1, D2);
    tbl[14] = mk(4'b0010, 0, 0, 0, 4'b0010, 1, 1, D1);
    tbl[15] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, D1);
    tbl[16] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, D1);
    tbl[17] = mk(4'b0000, 0, 1, 3, 4'b1000, 3, 1, D3);
    tbl[18] = mk(4'b0000, 0, 1, 1, 4'b0010, 1, 1, D1);
    tbl[19] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, D1);
    tbl[20] = mk(4'b1111, 0, 1, 2, 4'b0100, 2, 1, D2);
    for (int i = 21; i <= 24; i++) tbl[i] = mk(4'b1111, 0, 0, 0, 4'b1000, 3, 1, D3);
    tbl[25] = mk(4'b1111, 0, 0, 0, 4'b0001, 0, 1, D0);

    repeat (2) @(posedge clk);
    #1 chk("reset", 4'b0000, 2'd3, 1'b0, 32'h0);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req; lock = tbl[i].lock; force_en = tbl[i].fen; force_sel = tbl[i].fsel;
      @(posedge clk);
      #1 chk($sformatf("tbl[%0d]", i), tbl[i].grant, tbl[i].src, tbl[i].valid, tbl[i].num);
    end

    // Lock holds owner 0 well past the dwell time.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) req = 4'b1111; lock = 1'b1;
      @(posedge clk);
      #1 chk($sformatf("lock[%0d]", i), 4'b0001, 2'd0, 1'b1, D0);
    end
    @(negedge clk) req = 4'b1110;
    @(posedge clk);
    #1 chk("lock_drop", 4'b0010, 2'd1, 1'b1, D1);

    // Asynchronous reset between edges.
    @(negedge clk) lock = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_rst", 4'b0000, 2'd3, 1'b0, 32'h0);
    @(negedge clk) rst = 1'b0; req = 4'b1000;
    @(posedge clk);
    #1 chk("post_rst", 4'b1000, 2'd3, 1'b1, D3);

    // Random stimulus against the model.
    @(negedge clk) rst = 1'b1; req = '0; lock = 1'b0; force_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = 4'($urandom);
      lock = ($urandom_range(5) == 0);
      if ($urandom_range(19) == 0) force_en = ~force_en;
      force_sel = 2'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(1) == 0) dv[k] = $urandom;
      @(posedge clk);
      m_step();
      eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      #1 chk($sformatf("rand[%0d]", c), eg, 2'(m_last), m_owner >= 0, m_num);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
